// File: rtl/id_operand_ctrl_if.sv
// Decoder / regfile / forwarding bundle seen by the ID-stage operand controller.
// The master side drives the decoded instruction; the slave side returns operands and stall status.
interface id_operand_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    logic                       dec_valid_i;
    logic [RADDR_W-1:0]         rs1_i;
    logic [RADDR_W-1:0]         rs2_i;
    logic                       rs1_re_i;
    logic                       rs2_re_i;
    logic [RADDR_W-1:0]         rd_i;
    logic                       rd_we_i;
    logic                       is_load_i;
    logic [XLEN-1:0]            rf_rdata1_i;
    logic [XLEN-1:0]            rf_rdata2_i;
    logic [NUM_FWD-1:0]         fwd_we_i;
    logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i;
    logic [NUM_FWD*XLEN-1:0]    fwd_wdata_i;
    logic                       ext_stall_i;
    logic                       flush_i;
    logic [XLEN-1:0]            op1_o;
    logic [XLEN-1:0]            op2_o;
    logic                       stallreq_o;
    logic                       issue_o;
    logic [CNT_W-1:0]           stall_cnt_o;

    modport master (
        output dec_valid_i, rs1_i, rs2_i, rs1_re_i, rs2_re_i, rd_i, rd_we_i, is_load_i,
               rf_rdata1_i, rf_rdata2_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i,
               ext_stall_i, flush_i,
        input  op1_o, op2_o, stallreq_o, issue_o, stall_cnt_o
    );

    modport slave (
        input  dec_valid_i, rs1_i, rs2_i, rs1_re_i, rs2_re_i, rd_i, rd_we_i, is_load_i,
               rf_rdata1_i, rf_rdata2_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i,
               ext_stall_i, flush_i,
        output op1_o, op2_o, stallreq_o, issue_o, stall_cnt_o
    );
endinterface

// File: rtl/id_operand_ctrl.sv
// ID-stage operand resolution with a per-register pending-load scoreboard
// and a saturating stall-cycle counter for performance monitoring.
module id_operand_ctrl #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic               clk_i,
    input logic               rst_n_i,
    id_operand_ctrl_if.slave  bus
);
    localparam int NREG = 1 << RADDR_W;
    localparam int PW   = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [PW-1:0] LAT_V = PW'(LOAD_LAT);

    logic [PW-1:0]    pend [NREG];
    logic [CNT_W-1:0] stall_cnt;
    logic             hazard;
    logic             stallreq;
    logic             issue;

    // Lowest-index (youngest) forwarding hit wins; x0 and disabled reads always give zero.
    function automatic logic [XLEN-1:0] resolve(
        input logic                       en,
        input logic [RADDR_W-1:0]         rs,
        input logic [XLEN-1:0]            rf,
        input logic [NUM_FWD-1:0]         we,
        input logic [NUM_FWD*RADDR_W-1:0] wa,
        input logic [NUM_FWD*XLEN-1:0]    wd
    );
        logic [XLEN-1:0] v;
        v = rf;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (we[k] && (wa[k*RADDR_W +: RADDR_W] == rs)) v = wd[k*XLEN +: XLEN];
        end
        if (!en || (rs == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        hazard   = bus.dec_valid_i &&
                   ((bus.rs1_re_i && (bus.rs1_i != '0) && (pend[bus.rs1_i] != '0)) ||
                    (bus.rs2_re_i && (bus.rs2_i != '0) && (pend[bus.rs2_i] != '0)));
        stallreq = hazard && !bus.flush_i;
        issue    = bus.dec_valid_i && !stallreq && !bus.ext_stall_i && !bus.flush_i;
    end

    assign bus.op1_o       = resolve(bus.dec_valid_i && bus.rs1_re_i, bus.rs1_i, bus.rf_rdata1_i,
                                     bus.fwd_we_i, bus.fwd_waddr_i, bus.fwd_wdata_i);
    assign bus.op2_o       = resolve(bus.dec_valid_i && bus.rs2_re_i, bus.rs2_i, bus.rf_rdata2_i,
                                     bus.fwd_we_i, bus.fwd_waddr_i, bus.fwd_wdata_i);
    assign bus.stallreq_o  = stallreq;
    assign bus.issue_o     = issue;
    assign bus.stall_cnt_o = stall_cnt;

    // A newly issued writer overrides any in-flight countdown on its destination.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
        end else if (bus.flush_i) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (issue && bus.rd_we_i && (bus.rd_i == RADDR_W'(r))) begin
                    pend[r] <= bus.is_load_i ? LAT_V : '0;
                end else if ((pend[r] != '0) && !bus.ext_stall_i) begin
                    pend[r] <= pend[r] - PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
        end else if (stallreq && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule
